// File: rtl/assoc_pkg.sv
// Shared definitions for the class-score argmax block: default sizes and FSM encoding.
package assoc_pkg;

  localparam int NUM_CLASSES_DEF = 26;
  localparam int SCORE_W_DEF     = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/assoc_max_cmp.sv
// Combinational strict-greater select of two (score, index) pairs; on equal scores pair a is kept.
module assoc_max_cmp
  import assoc_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int IDX_W   = 5
) (
  input  logic [SCORE_W-1:0] a_score,
  input  logic [IDX_W-1:0]   a_idx,
  input  logic [SCORE_W-1:0] b_score,
  input  logic [IDX_W-1:0]   b_idx,
  output logic [SCORE_W-1:0] win_score,
  output logic [IDX_W-1:0]   win_idx
);

  // Strict compare keeps the earlier (lower-index) pair on ties.
  always_comb begin
    win_score = a_score;
    win_idx   = a_idx;
    if (b_score > a_score) begin
      win_score = b_score;
      win_idx   = b_idx;
    end
  end

endmodule

// File: rtl/assoc_score_argmax.sv
// Sequential argmax over per-class scores read through a 1-cycle registered mux.
// Optional threshold rejection is enabled by defining ASSOC_REJECT_EN.
module assoc_score_argmax
  import assoc_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  output logic [IDX_W-1:0]   score_sel,
  input  logic [SCORE_W-1:0] score_in,
  output logic               busy,
  output logic               pred_valid,
  input  logic               pred_ack,
  output logic [IDX_W-1:0]   pred_class,
  output logic [SCORE_W-1:0] pred_score,
`ifdef ASSOC_REJECT_EN
  input  logic [SCORE_W-1:0] reject_thr,
  output logic               pred_reject,
`endif
  output state_t             state
);

  // Handshake: pred_valid rises with a stable result and stays high, with
  // pred_class/pred_score/pred_reject unchanged, until sampled with pred_ack=1.

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] RD_END   = CNT_W'(NUM_CLASSES);
  localparam logic [CNT_W-1:0] CMP_FROM = CNT_W'(2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   rd_cnt;
  logic [IDX_W-1:0]   cmp_cnt;
  logic [SCORE_W-1:0] best_score;
  logic [IDX_W-1:0]   best_idx;
  logic [SCORE_W-1:0] win_score, upd_score;
  logic [IDX_W-1:0]   win_idx, upd_idx;
  logic               cmp_en, last_cmp;
`ifdef ASSOC_REJECT_EN
  logic [SCORE_W-1:0] thr_q;
`endif

  assign state = state_q;

  // The first SCAN cycle only waits out the mux read latency for class 0.
  assign cmp_en   = (state_q == SCAN) && (rd_cnt >= CMP_FROM);
  assign last_cmp = cmp_en && (cmp_cnt == LAST_IDX);

  assoc_max_cmp #(.SCORE_W(SCORE_W), .IDX_W(IDX_W)) u_cmp (
    .a_score   (best_score),
    .a_idx     (best_idx),
    .b_score   (score_in),
    .b_idx     (cmp_cnt),
    .win_score (win_score),
    .win_idx   (win_idx)
  );

  assign upd_score = (cmp_cnt == '0) ? score_in : win_score;
  assign upd_idx   = (cmp_cnt == '0) ? cmp_cnt  : win_idx;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (last_cmp) state_d = DONE;
      DONE:    if (pred_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      score_sel   <= '0;
      busy        <= 1'b0;
      pred_valid  <= 1'b0;
      pred_class  <= '0;
      pred_score  <= '0;
      rd_cnt      <= '0;
      cmp_cnt     <= '0;
      best_score  <= '0;
      best_idx    <= '0;
`ifdef ASSOC_REJECT_EN
      pred_reject <= 1'b0;
      thr_q       <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          score_sel <= '0;
          if (start) begin
            rd_cnt     <= CNT_W'(1);
            cmp_cnt    <= '0;
            best_score <= '0;
            best_idx   <= '0;
            busy       <= 1'b1;
`ifdef ASSOC_REJECT_EN
            thr_q      <= reject_thr;
`endif
          end
        end
        SCAN: begin
          score_sel <= (rd_cnt < RD_END) ? rd_cnt[IDX_W-1:0] : LAST_IDX;
          if (rd_cnt != RD_END) rd_cnt <= rd_cnt + CNT_W'(1);
          if (cmp_en) begin
            best_score <= upd_score;
            best_idx   <= upd_idx;
            cmp_cnt    <= cmp_cnt + IDX_W'(1);
          end
          if (last_cmp) begin
            pred_class  <= upd_idx;
            pred_score  <= upd_score;
            pred_valid  <= 1'b1;
            busy        <= 1'b0;
`ifdef ASSOC_REJECT_EN
            pred_reject <= (upd_score < thr_q);
`endif
          end
        end
        DONE: begin
          if (pred_ack) begin
            pred_valid  <= 1'b0;
`ifdef ASSOC_REJECT_EN
            pred_reject <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_score_argmax.sv
// Directed and randomized checks of assoc_score_argmax against a reference argmax model.
module tb_assoc_score_argmax;
  import assoc_pkg::*;

  localparam int N  = 26;
  localparam int SW = 13;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] score_sel;
  logic [SW-1:0] score_in = '0;
  logic          busy;
  logic          pred_valid;
  logic          pred_ack = 1'b0;
  logic [IW-1:0] pred_class;
  logic [SW-1:0] pred_score;
  state_t        state;
`ifdef ASSOC_REJECT_EN
  logic [SW-1:0] reject_thr = '0;
  logic          pred_reject;
`endif

  logic [SW-1:0] scores[N];
  int checks = 0;
  int errors = 0;

  assoc_score_argmax #(.NUM_CLASSES(N), .SCORE_W(SW)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .score_sel  (score_sel),
    .score_in   (score_in),
    .busy       (busy),
    .pred_valid (pred_valid),
    .pred_ack   (pred_ack),
    .pred_class (pred_class),
    .pred_score (pred_score),
`ifdef ASSOC_REJECT_EN
    .reject_thr (reject_thr),
    .pred_reject(pred_reject),
`endif
    .state      (state)
  );

  // Clock and the external registered class mux.
  always #5 clk = ~clk;
  always @(posedge clk) score_in <= scores[score_sel];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: the maximum value, then the first class that holds it.
  task automatic model(output logic [IW-1:0] e_idx, output logic [SW-1:0] e_score);
    int mx;
    mx = 0;
    foreach (scores[k]) if (int'(scores[k]) > mx) mx = int'(scores[k]);
    e_score = SW'(mx);
    e_idx = '0;
    for (int k = N - 1; k >= 0; k--) if (int'(scores[k]) == mx) e_idx = IW'(k);
  endtask

  task automatic fill(input int base, input int lo, input int hi);
    foreach (scores[k]) scores[k] = (hi < 0) ? SW'(base) : SW'($urandom_range(hi, lo));
  endtask

  task automatic run_scan(input string tag, input int thr);
    logic [IW-1:0] e_idx;
    logic [SW-1:0] e_score;
    int cyc;
    model(e_idx, e_score);
    @(negedge clk);
    start = 1'b1;
`ifdef ASSOC_REJECT_EN
    reject_thr = SW'(thr);
`endif
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy_hi"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!pred_valid && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    check({tag, "_latency"}, cyc, N + 1);
    check({tag, "_class"}, 32'(pred_class), 32'(e_idx));
    check({tag, "_score"}, 32'(pred_score), 32'(e_score));
    check({tag, "_busy_lo"}, 32'(busy), 32'd0);
`ifdef ASSOC_REJECT_EN
    check({tag, "_reject"}, 32'(pred_reject), 32'(int'(e_score) < thr));
`endif
  endtask

  task automatic do_ack(input string tag);
    logic [IW-1:0] c;
    logic [SW-1:0] s;
    c = pred_class;
    s = pred_score;
    @(negedge clk);
    pred_ack = 1'b1;
    @(posedge clk);
    #1 pred_ack = 1'b0;
    check({tag, "_ack_valid"}, 32'(pred_valid), 32'd0);
    check({tag, "_ack_class_kept"}, 32'(pred_class), 32'(c));
    check({tag, "_ack_score_kept"}, 32'(pred_score), 32'(s));
`ifdef ASSOC_REJECT_EN
    check({tag, "_ack_reject"}, 32'(pred_reject), 32'd0);
`endif
  endtask

  initial begin
    fill(0, 0, -1);
    #12;
    check("rst_valid", 32'(pred_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sel", 32'(score_sel), 32'd0);
    check("rst_class", 32'(pred_class), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    @(negedge clk);
    nrst = 1'b1;

    // An ack while idle must not disturb anything.
    @(negedge clk);
    pred_ack = 1'b1;
    @(negedge clk);
    pred_ack = 1'b0;
    check("idle_ack_state", 32'(state), 32'(IDLE));

    foreach (scores[k]) scores[k] = SW'(k * 10);
    scores[17] = 13'd5000;
    run_scan("unique", 0);
    do_ack("unique");

    fill(100, 0, -1);
    scores[3] = 13'd8191;
    scores[20] = 13'd8191;
    run_scan("tie", 0);
    do_ack("tie");

    fill(0, 0, -1);
    scores[0] = 13'd1;
    run_scan("first", 0);
    do_ack("first");

    fill(0, 0, 400);
    scores[25] = 13'd7000;
    run_scan("last", 0);

    // Result must hold through a stalled ack while start pulses are ignored.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = (i % 3 == 0);
      @(negedge clk);
      start = 1'b0;
      check("hold_valid", 32'(pred_valid), 32'd1);
      check("hold_class", 32'(pred_class), 32'd25);
      check("hold_score", 32'(pred_score), 32'd7000);
    end
    // start together with ack: ack taken, start dropped.
    @(negedge clk);
    start = 1'b1;
    pred_ack = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pred_ack = 1'b0;
    check("ack_start_valid", 32'(pred_valid), 32'd0);
    @(posedge clk);
    #1 check("ack_start_dropped", 32'(state), 32'(IDLE));
    check("ack_start_busy", 32'(busy), 32'd0);

    fill(0, 0, 8191);
    run_scan("fresh", 0);
    do_ack("fresh");

    // Reset during the scan discards the partial result.
    fill(0, 0, 8191);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(pred_valid), 32'd0);
    check("midrst_class", 32'(pred_class), 32'd0);
    check("midrst_score", 32'(pred_score), 32'd0);
    check("midrst_sel", 32'(score_sel), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    run_scan("post_rst", 0);
    do_ack("post_rst");

    fill(0, 0, -1);
    run_scan("zeros", 0);
    do_ack("zeros");

    for (int r = 0; r < 6; r++) begin
      fill(0, 0, (r < 3) ? 3 : 8191);
      run_scan("rand", int'($urandom_range(8191, 0)));
      do_ack("rand");
    end

`ifdef ASSOC_REJECT_EN
    fill(0, 0, 900);
    scores[9] = 13'd999;
    run_scan("rej_below", 1000);
    do_ack("rej_below");
    scores[9] = 13'd1000;
    run_scan("rej_equal", 1000);
    do_ack("rej_equal");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/assoc_score_argmax.md
Name: assoc_score_argmax

Overview:
- Reads the per-class accumulated similarity scores after an inference has finished accumulating.
- Scans all classes sequentially and finds the class with the largest score.
- Presents the winning class index and score to the downstream classifier output through a valid/ack handshake.
- Sits between the bank of per-class score accumulators, read through an external registered class mux, and the result interface.

Parameters:
- NUM_CLASSES, 26, number of class scores scanned per inference (must be >= 2).
- SCORE_W, 13, width of each accumulated score (unsigned).
- IDX_W, $clog2(NUM_CLASSES), width of the class index.

Ports:
- clk  input  1  clock.
- nrst  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse: all accumulators are final, begin scan.
- score_sel  output  IDX_W  class index driven to the external score mux.
- score_in  input  SCORE_W  score of the class selected by score_sel one cycle earlier (1-cycle read latency).
- busy  output  1  high from the cycle after an accepted start until pred_valid rises.
- pred_valid  output  1  result valid; held until acknowledged.
- pred_ack  input  1  downstream consumes the result.
- pred_class  output  IDX_W  winning class index.
- pred_score  output  SCORE_W  winning score.

Behaviour:
- Reset (async, nrst=0): state=IDLE; score_sel=0, busy=0, pred_valid=0, pred_class=0, pred_score=0; internal max/index/counters cleared.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - score_sel=0.
  - start=1 -> SCAN; rd_cnt=1, cmp_cnt=0, best_score=0, best_idx=0.
  - score_sel advances to 1 on entry.
- SCAN: each cycle:
  - score_in corresponds to class cmp_cnt.
  - Update rule: if cmp_cnt==0 or score_in > best_score (strict), then best_score<=score_in and best_idx<=cmp_cnt.
  - cmp_cnt increments.
  - score_sel=rd_cnt while rd_cnt<NUM_CLASSES, then holds NUM_CLASSES-1.
- SCAN exit: when cmp_cnt==NUM_CLASSES-1 is compared -> DONE.
  - pred_class/pred_score load the final comparison result in the same edge.
  - pred_valid<=1, busy<=0.
- Latency: start accepted at edge T; pred_valid high at edge T+NUM_CLASSES+1 (SCAN lasts NUM_CLASSES cycles, plus one cycle of read latency on the first address).
- Ties: lowest index wins, because only strict > replaces.
- Unsigned compare, full SCORE_W width; no saturation or truncation.
- DONE:
  - pred_valid, pred_class and pred_score are held stable.
  - pred_ack=1 -> IDLE, pred_valid<=0; pred_class/pred_score retain their last value.
- start while in SCAN or DONE is ignored; no queuing.
- start and pred_ack in the same DONE cycle: ack taken, start dropped.
- pred_ack outside DONE is ignored.
- Reset mid-scan: immediate return to the reset values; partial results are discarded.
- All-zero scores: pred_class=0, pred_score=0.

Optional Feature:
- Macro ASSOC_REJECT_EN. When defined, adds:
  - input reject_thr [SCORE_W-1:0], sampled at start.
  - output pred_reject, reset 0.
- In DONE, pred_reject=1 if best_score < sampled threshold, else 0; it is cleared together with pred_valid.
- When undefined, neither port exists and results are never rejected.

Decomposition:
- Shared package assoc_pkg:
  - SCORE_W and NUM_CLASSES defaults, matching the accumulator score width.
  - state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2).
- One natural sub-module, assoc_max_cmp: combinational strict-greater compare/select of (score, index) pairs. It is reusable for a future tree argmax.
- The FSM and counters stay in the top module.

Test Plan:
- Unique max: NUM_CLASSES=26, scores[k]=k*10 except scores[17]=5000, start -> pred_valid at start+27 cycles, pred_class=17, pred_score=5000.
- Tie, lowest index wins: scores[3]=scores[20]=8191 (max), rest 100 -> pred_class=3, pred_score=8191.
- Boundary indices:
  - max only at class 0 (score 1) with all others 0 -> pred_class=0.
  - max at class 25 -> pred_class=25; covers first and last comparison.
- Handshake:
  - hold pred_ack=0 for 10 cycles -> outputs stable, start pulses ignored.
  - pred_ack=1 -> pred_valid=0 next cycle.
  - new start then yields a fresh result.
- Reset mid-scan: assert nrst=0 at scan cycle 12 -> all outputs 0 immediately; after release, a full scan gives the correct result.
- ASSOC_REJECT_EN: reject_thr=1000, max score=999 -> pred_reject=1; max score=1000 -> pred_reject=0.
